axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
Two-requester round-robin arbiter sharing the single SDRAM AXI read port (AR + R channels, 16-bit word data, 25-bit word address) between two read masters, e.g. the test read controller and a display/DMA reader. Grant is locked from address acceptance until the last beat of the burst. It sits between the read masters and the SDRAM AXI slave.

Parameters:
ADDR_W, 25, word address width
DATA_W, 16, read data width
LEN_W, 8, ARLEN width (beats-1)
TIMEOUT_CYC, 1024, watchdog limit in cycles without an R beat (optional feature only)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
mN_arvalid  input  1  requester N address valid (N=0,1)
mN_arready  output  1  requester N address accepted
mN_araddr  input  ADDR_W  requester N word address
mN_arlen  input  LEN_W  requester N burst length-1
mN_rvalid  output  1  read beat valid to requester N
mN_rready  input  1  requester N ready for beat
mN_rdata  output  DATA_W  read data to requester N
mN_rresp  output  2  read response to requester N
mN_rlast  output  1  last beat to requester N
s_arvalid  output  1  to slave
s_arready  input  1  from slave
s_araddr  output  ADDR_W  to slave
s_arlen  output  LEN_W  to slave
s_rvalid  input  1  from slave
s_rready  output  1  to slave
s_rdata  input  DATA_W  from slave
s_rresp  input  2  from slave
s_rlast  input  1  from slave
grant  output  1  index of current/last granted requester
busy  output  1  high in ADDR or DATA state
timeout_err  output  1  sticky watchdog flag (0 when feature disabled)

Behaviour:
- Clock clk, reset asynchronous active-low on reset_n; all state registers clear on assertion, irrespective of clk.
- Reset values: state=IDLE, s_arvalid=0, s_araddr=0, s_arlen=0, grant=1 (so requester 0 wins first tie), busy=0, timeout_err=0; all mN_* outputs 0.
- States: IDLE, ADDR, DATA.
- IDLE: if any mN_arvalid, pick winner: single requester wins; both -> requester != grant. Register winner into grant, latch its araddr/arlen into s_araddr/s_arlen, set s_arvalid=1, go ADDR. Latency: arvalid sampled at edge t -> s_arvalid high after edge t.
- ADDR: s_arvalid held with stable address/len. mN_arready = (state==ADDR) & (grant==N) & s_arready, combinational. On s_arvalid&s_arready: clear s_arvalid, go DATA.
- DATA: R channel routed combinationally to granted requester: mN_rvalid = s_rvalid & (grant==N); rdata/rresp/rlast broadcast, qualified only by rvalid. s_rready = granted mN_rready. Non-granted requester sees rvalid=0 and arready=0.
- On s_rvalid & s_rready & s_rlast: go IDLE; a new grant is possible on the next edge (one idle cycle between bursts).
- Requester arvalid dropping while not granted is tolerated (no latch until IDLE pick). Grant register is not changed by requests arriving in ADDR/DATA.
- Ownership ends only on the rlast beat; beat count is not checked.
- busy = (state != IDLE).
- Reset mid-burst: immediate return to IDLE with s_arvalid=0 and s_rready=0; the slave must be reset alongside.

Optional Feature:
Macro AXI_RD_ARB_TIMEOUT_EN. When defined: a counter of width clog2(TIMEOUT_CYC)+1 clears on entering DATA and on every R handshake, and increments each DATA cycle without one. On reaching TIMEOUT_CYC it sets timeout_err (sticky until reset) and forces state to IDLE. When undefined: no counter; timeout_err tied 0; DATA waits indefinitely.

Decomposition:
- Package axi_rd_arb_pkg: state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and default widths (25/16/8).
- One sub-module, rr_pick2: a combinational 2-way round-robin selector (inputs: req[1:0], last grant; outputs: valid, winner).

Test Plan:
- Only m0 requests addr 0x0000100, len 31, slave arready delayed 3 cycles -> s_araddr=0x0000100, s_arlen=31; m0_arready pulses once; 32 beats reach m0 only; busy falls after the rlast beat.
- m0 and m1 request simultaneously from reset -> m0 served first, then m1; next simultaneous pair is served m0 then m1 again (strict alternation).
- m1 asserts arvalid during an m0 DATA phase -> m1_arready and m1_rvalid stay 0 until m0 rlast; m1's s_arvalid rises 1 cycle after m0's return to IDLE.
- m0_rready toggled 0/1 during a 4-beat burst -> s_rready mirrors it; no beat lost or duplicated (data 0xA000..0xA003 in order).
- reset_n pulsed low in DATA mid-burst, asynchronous to clk -> outputs reach reset values without a clk edge; a fresh request after release completes normally.
- AXI_RD_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave stops rvalid after beat 2 -> timeout_err=1 exactly 16 cycles later, state IDLE, flag held until reset.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
// Shared encodings and default widths for the two-master AXI read arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_rd_arb_pkg;

    localparam int DEF_ADDR_W      = 25;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_LEN_W       = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not granted last wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       vld_o,
    output logic       winner_o
);

    assign vld_o    = |req_i;
    assign winner_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin share of one AXI read port (AR+R) between two masters; optional watchdog via AXI_RD_ARB_TIMEOUT_EN.
// Latency: AR registered one cycle after arvalid is sampled; R is routed combinationally to the owner.
// Backpressure: slave arready/rvalid pass straight to the owner; owner rready drives s_rready; loser sees no arready.
module axi_read_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [LEN_W-1:0]  m0_arlen,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [LEN_W-1:0]  m1_arlen,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [LEN_W-1:0]  s_arlen,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic              pick_vld, pick_win;
    logic              in_addr, in_data, r_hs, wd_fire;

    rr_pick2 u_pick (
        .req_i   ({m1_arvalid, m0_arvalid}),
        .last_i  (grant_q),
        .vld_o   (pick_vld),
        .winner_o(pick_win)
    );

    assign in_addr  = (state_q == ADDR);
    assign in_data  = (state_q == DATA);
    assign s_rready = in_data & (grant_q ? m1_rready : m0_rready);
    assign r_hs     = s_rvalid & s_rready;

    assign m0_arready = in_addr & ~grant_q & s_arready;
    assign m1_arready = in_addr &  grant_q & s_arready;
    assign m0_rvalid  = in_data & ~grant_q & s_rvalid;
    assign m1_rvalid  = in_data &  grant_q & s_rvalid;
    assign m0_rdata   = m0_rvalid ? s_rdata : '0;
    assign m0_rresp   = m0_rvalid ? s_rresp : 2'b00;
    assign m0_rlast   = m0_rvalid & s_rlast;
    assign m1_rdata   = m1_rvalid ? s_rdata : '0;
    assign m1_rresp   = m1_rvalid ? s_rresp : 2'b00;
    assign m1_rlast   = m1_rvalid & s_rlast;

    assign s_arvalid = arvalid_q;
    assign s_araddr  = araddr_q;
    assign s_arlen   = arlen_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

`ifdef AXI_RD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             terr_q;

    // Counter is held at zero outside DATA, so entering DATA always starts from zero.
    always_comb begin
        wd_cnt_d = '0;
        if (in_data && !r_hs) wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end

    assign wd_fire     = (wd_cnt_d == CNT_W'(TIMEOUT_CYC));
    assign timeout_err = terr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            terr_q   <= terr_q | wd_fire;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick_win;
                    araddr_d  = pick_win ? m1_araddr : m0_araddr;
                    arlen_d   = pick_win ? m1_arlen  : m0_arlen;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                // Ownership ends on the rlast handshake alone; beats are not counted.
                if ((r_hs && s_rlast) || wd_fire) state_d = IDLE;
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b1;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed bursts, a behavioural slave, and an owner-level reference model.
module tb_axi_read_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int TO = 16;

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] l;
    } req_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic          m0_arvalid = 1'b0, m1_arvalid = 1'b0;
    logic          m0_arready, m1_arready;
    logic [AW-1:0] m0_araddr = '0, m1_araddr = '0;
    logic [LW-1:0] m0_arlen = '0, m1_arlen = '0;
    logic          m0_rvalid, m1_rvalid;
    logic          m0_rready = 1'b1, m1_rready = 1'b1;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    m0_rresp, m1_rresp;
    logic          m0_rlast, m1_rlast;
    logic          s_arvalid, s_rready;
    logic          s_arready = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0;
    logic [AW-1:0] s_araddr;
    logic [LW-1:0] s_arlen;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = 2'b00;
    logic          grant, busy, timeout_err;

    axi_read_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .LEN_W(LW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- requesters ----------------
    req_t req0_q[$], req1_q[$];
    req_t r0, r1;
    logic hs0 = 1'b0, hs1 = 1'b0;
    logic tog0 = 1'b0;

    always @(negedge clk) begin
        hs0 = m0_arvalid & m0_arready;
        hs1 = m1_arvalid & m1_arready;
    end

    always @(posedge clk) begin
        #1;
        if (hs0) m0_arvalid = 1'b0;
        if (hs1) m1_arvalid = 1'b0;
        if (!m0_arvalid && req0_q.size() > 0) begin
            r0 = req0_q.pop_front();
            m0_araddr = r0.a; m0_arlen = r0.l; m0_arvalid = 1'b1;
        end
        if (!m1_arvalid && req1_q.size() > 0) begin
            r1 = req1_q.pop_front();
            m1_araddr = r1.a; m1_arlen = r1.l; m1_arvalid = 1'b1;
        end
        m0_rready = tog0 ? ~m0_rready : 1'b1;
    end

    // ---------------- behavioural slave ----------------
    int            sl_ph = 0, sl_dly = 0, sl_beat = 0;
    int            ar_dly = 0, stop_after = -1;
    logic [LW-1:0] sl_len = '0, cap_len;
    logic [DW-1:0] data_base = '0;
    logic          hs_ar, hs_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sl_ph = 0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        end else begin
            hs_ar = s_arvalid & s_arready;
            hs_r = s_rvalid & s_rready;
            cap_len = s_arlen;
            #1;
            if (hs_ar) begin
                s_arready = 1'b0; sl_len = cap_len; sl_beat = 0; sl_ph = 2;
            end else if (sl_ph == 0 && s_arvalid) begin
                sl_dly = ar_dly; sl_ph = 1;
            end
            if (sl_ph == 1) begin
                if (sl_dly == 0) s_arready = 1'b1;
                else sl_dly--;
            end
            if (sl_ph == 2 && hs_r) begin
                if (s_rlast) sl_ph = 0;
                else sl_beat++;
            end
            s_rvalid = (sl_ph == 2) && (stop_after < 0 || sl_beat < stop_after);
            s_rlast = s_rvalid && (sl_beat == int'(sl_len));
            s_rdata = s_rvalid ? data_base + DW'(sl_beat) : '0;
            s_rresp = s_rvalid ? 2'(sl_beat) : 2'b00;
        end
    end

    // ---------------- reference model: who owns the port and what is owed ----------------
    int            m_owner = -1, m_idle = 0;
    logic          m_last = 1'b1, m_pend = 1'b0, m_err = 1'b0, m_rr;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_len = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_last = 1'b1; m_pend = 1'b0; m_err = 1'b0; m_idle = 0;
        end else if (m_owner < 0) begin
            if (m0_arvalid || m1_arvalid) begin
                if (m0_arvalid && m1_arvalid) m_owner = m_last ? 0 : 1;
                else m_owner = m1_arvalid ? 1 : 0;
                m_last = (m_owner == 1);
                m_addr = m_last ? m1_araddr : m0_araddr;
                m_len = m_last ? m1_arlen : m0_arlen;
                m_pend = 1'b1;
            end
        end else if (m_pend) begin
            if (s_arready) begin m_pend = 1'b0; m_idle = 0; end
        end else begin
            m_rr = (m_owner == 1) ? m1_rready : m0_rready;
            if (s_rvalid && m_rr) begin
                m_idle = 0;
                if (s_rlast) m_owner = -1;
            end else begin
                m_idle++;
`ifdef AXI_RD_ARB_TIMEOUT_EN
                if (m_idle == TO) begin m_err = 1'b1; m_owner = -1; end
`endif
            end
        end
    end

    // ---------------- beat recorder ----------------
    logic [DW-1:0] rx0[$], rx1[$];
    int last_hs_cyc = 0, rlast0_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (m0_rvalid && m0_rready) begin
            rx0.push_back(m0_rdata);
            last_hs_cyc = cyc;
            if (m0_rlast) rlast0_cyc = cyc;
        end
        if (m1_rvalid && m1_rready) rx1.push_back(m1_rdata);
    end

    // ---------------- per-cycle compare ----------------
    logic [AW-1:0] ord_q[$];
    logic [AW-1:0] rise_addr = '0;
    logic [LW-1:0] rise_len = '0;
    int   rise_cyc = 0, fall_cyc = 0, err_cyc = 0, n_arr0 = 0;
    logic prev_arv = 1'b0, prev_busy = 1'b0, prev_err = 1'b0, exp_ar, exp_dat;

    always @(negedge clk) begin
        exp_ar = (m_owner >= 0) && m_pend;
        exp_dat = (m_owner >= 0) && !m_pend;
        chk("busy", busy, m_owner >= 0);
        chk("grant", grant, m_last);
        chk("s_arvalid", s_arvalid, exp_ar);
        if (exp_ar) begin
            chk("s_araddr", s_araddr, m_addr);
            chk("s_arlen", s_arlen, m_len);
        end
        chk("m0_arready", m0_arready, exp_ar && m_owner == 0 && s_arready);
        chk("m1_arready", m1_arready, exp_ar && m_owner == 1 && s_arready);
        chk("m0_rvalid", m0_rvalid, exp_dat && m_owner == 0 && s_rvalid);
        chk("m1_rvalid", m1_rvalid, exp_dat && m_owner == 1 && s_rvalid);
        chk("s_rready", s_rready, exp_dat && ((m_owner == 1) ? m1_rready : m0_rready));
        if (m0_rvalid) chk("m0_beat", {m0_rlast, m0_rresp, m0_rdata}, {s_rlast, s_rresp, s_rdata});
        if (m1_rvalid) chk("m1_beat", {m1_rlast, m1_rresp, m1_rdata}, {s_rlast, s_rresp, s_rdata});
        chk("timeout_err", timeout_err, m_err);
        if (s_arvalid && !prev_arv) begin
            ord_q.push_back(s_araddr); rise_addr = s_araddr; rise_len = s_arlen; rise_cyc = cyc;
        end
        if (!busy && prev_busy) fall_cyc = cyc;
        if (timeout_err && !prev_err) err_cyc = cyc;
        if (m0_arready) n_arr0++;
        prev_arv = s_arvalid; prev_busy = busy; prev_err = timeout_err;
    end

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (n < budget && (busy || m0_arvalid || m1_arvalid || req0_q.size() > 0 || req1_q.size() > 0)) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < budget, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_rx0(input string nm, input int cnt);
        for (int i = 0; i < 200 && rx0.size() < cnt; i++) @(negedge clk);
        chk(nm, rx0.size() >= cnt, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 1);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_s_arlen", s_arlen, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m_out", {m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
        chk("rst_timeout_err", timeout_err, 0);
        #19 reset_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests from reset: strict alternation m0, m1, m0, m1.
        ar_dly = 0; data_base = 16'h2000;
        req0_q.push_back('{25'h0000200, 8'd3});
        req1_q.push_back('{25'h1000300, 8'd3});
        wait_idle("t2_pair1_done", 300);
        req0_q.push_back('{25'h0000210, 8'd3});
        req1_q.push_back('{25'h1000310, 8'd3});
        wait_idle("t2_pair2_done", 300);
        chk("t2_ar_count", ord_q.size(), 4);
        if (ord_q.size() == 4) begin
            chk("t2_ord0", ord_q[0], 25'h0000200);
            chk("t2_ord1", ord_q[1], 25'h1000300);
            chk("t2_ord2", ord_q[2], 25'h0000210);
            chk("t2_ord3", ord_q[3], 25'h1000310);
        end
        chk("t2_rx0", rx0.size(), 8);
        chk("t2_rx1", rx1.size(), 8);

        // Single 32-beat burst from m0 with slow arready.
        rx0.delete(); rx1.delete(); n_arr0 = 0;
        ar_dly = 3; data_base = 16'h1000;
        req0_q.push_back('{25'h0000100, 8'd31});
        wait_idle("t1_done", 300);
        chk("t1_araddr", rise_addr, 25'h0000100);
        chk("t1_arlen", rise_len, 31);
        chk("t1_arready_pulses", n_arr0, 1);
        chk("t1_rx0", rx0.size(), 32);
        chk("t1_rx1", rx1.size(), 0);
        if (rx0.size() == 32) begin
            chk("t1_first", rx0[0], 16'h1000);
            chk("t1_last", rx0[31], 16'h101F);
        end
        chk("t1_busy_fall", fall_cyc, rlast0_cyc);

        // m1 arrives mid m0 DATA: its AR rises one cycle after m0 returns to IDLE.
        rx0.delete(); rx1.delete();
        ar_dly = 1; data_base = 16'h3000;
        req0_q.push_back('{25'h0000400, 8'd7});
        wait_rx0("t3_mid", 2);
        req1_q.push_back('{25'h1000500, 8'd3});
        wait_idle("t3_done", 300);
        chk("t3_araddr", rise_addr, 25'h1000500);
        chk("t3_gap", rise_cyc - rlast0_cyc, 1);
        chk("t3_rx0", rx0.size(), 8);
        chk("t3_rx1", rx1.size(), 4);

        // rready toggling: every beat delivered exactly once, in order.
        rx0.delete(); rx1.delete();
        ar_dly = 0; data_base = 16'hA000; tog0 = 1'b1;
        req0_q.push_back('{25'h0000600, 8'd3});
        wait_idle("t4_done", 300);
        tog0 = 1'b0;
        chk("t4_rx0", rx0.size(), 4);
        if (rx0.size() == 4) for (int i = 0; i < 4; i++) chk("t4_beat", rx0[i], 16'hA000 + 16'(i));

        // Asynchronous reset mid-burst, then a clean burst.
        rx0.delete(); data_base = 16'h5000;
        req0_q.push_back('{25'h0000700, 8'd15});
        wait_rx0("t5_mid", 3);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_grant", grant, 1);
        chk("t5_s_arvalid", s_arvalid, 0);
        chk("t5_s_rready", s_rready, 0);
        chk("t5_s_araddr", s_araddr, 0);
        @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        rx0.delete(); data_base = 16'h6000;
        req0_q.push_back('{25'h0000800, 8'd3});
        wait_idle("t5_after", 300);
        chk("t5_rx0", rx0.size(), 4);
        if (rx0.size() == 4) chk("t5_last", rx0[3], 16'h6003);

`ifdef AXI_RD_ARB_TIMEOUT_EN
        // Slave stalls after two beats: watchdog fires TO cycles after the last handshake.
        rx0.delete(); data_base = 16'h7000; stop_after = 2;
        req0_q.push_back('{25'h0000900, 8'd7});
        for (int i = 0; i < 300 && !timeout_err; i++) @(negedge clk);
        @(negedge clk);
        chk("t6_err_set", timeout_err, 1);
        chk("t6_delay", err_cyc - last_hs_cyc, TO);
        chk("t6_rx0", rx0.size(), 2);
        chk("t6_idle", busy, 0);
        repeat (5) @(negedge clk);
        chk("t6_sticky", timeout_err, 1);
        stop_after = -1;
        #2 reset_n = 1'b0;
        #1 chk("t6_cleared", timeout_err, 0);
        @(negedge clk);
        #3 reset_n = 1'b1;
        repeat (2) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
